exe_stage_mc: RTL

//  Parametrised multi-cycle execute stage of the 5-stage ARM pipeline, between ID/EXE and MEM.

---
 rtl/exe_stage_mc.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: ARM execute stage (forwarding, val2, ALU, NZCV, EXE/MEM register).
// Define EXE_MUL_EN to build in the iterative shift-add MUL and its stall FSM.
module exe_stage_mc #(
    parameter int DW      = 32,
    parameter int MUL_BPC = 2,
    parameter int RW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic [DW-1:0] pc_EXE,
    input  logic [DW-1:0] rn_val_EXE,
    input  logic [DW-1:0] rm_val_EXE,
    input  logic [DW-1:0] val_WB,
    input  logic [23:0]   signed_imm_24_EXE,
    input  logic [11:0]   shifter_operand_EXE,
    input  logic [3:0]    exe_cmd_EXE,
    input  logic [RW-1:0] dest_EXE,
    input  logic          WB_EN_EXE,
    input  logic          MEM_R_EN_EXE,
    input  logic          MEM_W_EN_EXE,
    input  logic          S_EXE,
    input  logic          imm_EXE,
    input  logic [1:0]    sel_src1_FWRD,
    input  logic [1:0]    sel_src2_FWRD,
    output logic [DW-1:0] branch_address_IF,
    output logic [3:0]    status_ID,
    output logic          stall_EXE,
    output logic [DW-1:0] alu_res_MEM,
    output logic [DW-1:0] rm_val_MEM,
    output logic [RW-1:0] dest_MEM,
    output logic          WB_EN_MEM,
    output logic          MEM_R_EN_MEM,
    output logic          MEM_W_EN_MEM
);
    localparam logic [3:0] C_MOV = 4'd1;
    localparam logic [3:0] C_ADD = 4'd2;
    localparam logic [3:0] C_ADC = 4'd3;
    localparam logic [3:0] C_SUB = 4'd4;
    localparam logic [3:0] C_SBC = 4'd5;
    localparam logic [3:0] C_AND = 4'd6;
    localparam logic [3:0] C_ORR = 4'd7;
    localparam logic [3:0] C_EOR = 4'd8;
    localparam logic [3:0] C_MVN = 4'd9;
`ifdef EXE_MUL_EN
    localparam logic [3:0] C_MUL = 4'd10;
`endif

    if ((DW % 2) != 0 || DW < 16 || (DW % MUL_BPC) != 0) begin : g_bad_cfg
        $error("exe_stage_mc: unsupported DW/MUL_BPC");
    end

    logic signed [23:0] simm;
    assign simm = signed_imm_24_EXE;
    assign branch_address_IF = pc_EXE + (DW'(simm) << 2);

    logic [DW-1:0] val1, rm_f, val2, imm8, res, opb;
    logic [DW:0]   sum;
    logic [4:0]    sh_amt, rot_amt;
    logic [3:0]    nzcv;
    logic          cin, ovf, arith, upd;

    always_comb begin
        unique case (sel_src1_FWRD)
            2'd1:    val1 = alu_res_MEM;
            2'd2:    val1 = val_WB;
            default: val1 = rn_val_EXE;
        endcase
        unique case (sel_src2_FWRD)
            2'd1:    rm_f = alu_res_MEM;
            2'd2:    rm_f = val_WB;
            default: rm_f = rm_val_EXE;
        endcase
    end

    assign sh_amt  = shifter_operand_EXE[11:7];
    assign rot_amt = {shifter_operand_EXE[11:8], 1'b0};
    assign imm8    = DW'(shifter_operand_EXE[7:0]);

    // A shift by DW yields zero, which makes the zero-amount rotate fall out naturally.
    always_comb begin
        val2 = '0;
        if (MEM_R_EN_EXE || MEM_W_EN_EXE) begin
            val2 = DW'(shifter_operand_EXE);
        end else if (imm_EXE) begin
            val2 = (imm8 >> rot_amt) | (imm8 << (DW - int'(rot_amt)));
        end else begin
            unique case (shifter_operand_EXE[6:5])
                2'd0:    val2 = rm_f << sh_amt;
                2'd1:    val2 = rm_f >> sh_amt;
                2'd2:    val2 = $signed(rm_f) >>> sh_amt;
                default: val2 = (rm_f >> sh_amt) | (rm_f << (DW - int'(sh_amt)));
            endcase
        end
    end

    // Subtraction is val1 + ~val2 + cin, so C is NOT borrow and one V rule covers both.
    assign opb = (exe_cmd_EXE == C_SUB || exe_cmd_EXE == C_SBC) ? ~val2 : val2;

    always_comb begin
        cin = 1'b0;
        unique case (exe_cmd_EXE)
            C_SUB:        cin = 1'b1;
            C_ADC, C_SBC: cin = status_ID[1];
            default:      cin = 1'b0;
        endcase
    end

    assign sum = {1'b0, val1} + {1'b0, opb} + {{DW{1'b0}}, cin};
    assign ovf = (val1[DW-1] == opb[DW-1]) && (sum[DW-1] != val1[DW-1]);

`ifdef EXE_MUL_EN
    localparam int ITERS = DW / MUL_BPC;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mstate_t;

    mstate_t       state, state_nx;
    logic [DW-1:0] prod, mcand, mplr, part;
    logic [DW-1:0] prod_nx, mcand_nx, mplr_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          is_mul;

    assign is_mul    = exe_cmd_EXE == C_MUL;
    assign stall_EXE = is_mul && state != S_DONE && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            prod  <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            prod  <= prod_nx;
            mcand <= mcand_nx;
            mplr  <= mplr_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        prod_nx  = prod;
        mcand_nx = mcand;
        mplr_nx  = mplr;
        cnt_nx   = cnt;
        part     = '0;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (mplr[j]) part = part + (mcand << j);
        end
        unique case (state)
            S_IDLE: begin
                if (is_mul) begin
                    state_nx = S_BUSY;
                    prod_nx  = '0;
                    mcand_nx = val1;
                    mplr_nx  = val2;
                    cnt_nx   = '0;
                end
            end
            S_BUSY: begin
                prod_nx  = prod + part;
                mcand_nx = mcand << MUL_BPC;
                mplr_nx  = mplr >> MUL_BPC;
                cnt_nx   = cnt + 1'b1;
                if (cnt == CW'(ITERS - 1)) state_nx = S_DONE;
            end
            S_DONE: begin
                if (!freeze) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
`else
    assign stall_EXE = 1'b0;
`endif

    always_comb begin
        res   = '0;
        arith = 1'b0;
        upd   = 1'b1;
        case (exe_cmd_EXE)
            C_MOV: res = val2;
            C_MVN: res = ~val2;
            C_ADD, C_ADC, C_SUB, C_SBC: begin
                res   = sum[DW-1:0];
                arith = 1'b1;
            end
            C_AND: res = val1 & val2;
            C_ORR: res = val1 | val2;
            C_EOR: res = val1 ^ val2;
`ifdef EXE_MUL_EN
            C_MUL: res = prod;
`endif
            default: upd = 1'b0;
        endcase
        nzcv = status_ID;
        if (upd) begin
            nzcv[3] = res[DW-1];
            nzcv[2] = res == '0;
            if (arith) nzcv[1:0] = {sum[DW], ovf};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_ID <= '0;
        end else if (S_EXE && !freeze && !stall_EXE) begin
            status_ID <= nzcv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_MEM  <= '0;
            rm_val_MEM   <= '0;
            dest_MEM     <= '0;
            WB_EN_MEM    <= 1'b0;
            MEM_R_EN_MEM <= 1'b0;
            MEM_W_EN_MEM <= 1'b0;
        end else if (!freeze) begin
            if (stall_EXE) begin
                alu_res_MEM  <= '0;
                rm_val_MEM   <= '0;
                dest_MEM     <= '0;
                WB_EN_MEM    <= 1'b0;
                MEM_R_EN_MEM <= 1'b0;
                MEM_W_EN_MEM <= 1'b0;
            end else begin
                alu_res_MEM  <= res;
                rm_val_MEM   <= rm_f;
                dest_MEM     <= dest_EXE;
                WB_EN_MEM    <= WB_EN_EXE;
                MEM_R_EN_MEM <= MEM_R_EN_EXE;
                MEM_W_EN_MEM <= MEM_W_EN_EXE;
            end
        end
    end
endmodule
